srt_result_collector: RTL and testbench



---
 rtl/srt_result_collector_if.sv | 29 ++
 rtl/srt_result_collector.sv | 120 ++++++++++++
 tb/tb_srt_result_collector.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/srt_result_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | srt_result_collector_if: issue handshake, systolic results, AXIS output  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface srt_result_collector_if #(
  parameter int OUT_WIDTH = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [OUT_WIDTH-1:0] result0;
  logic [OUT_WIDTH-1:0] result1;
  logic [OUT_WIDTH-1:0] result2;
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;

  modport slave (
    input  s_valid, result0, result1, result2, m_axis_tready,
    output s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_valid, result0, result1, result2, m_axis_tready,
    input  s_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface
`default_nettype wire

// File: rtl/srt_result_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | srt_result_collector: credit-gated capture of systolic result triplets,  |
// | FIFO buffering and 3-beat AXI-Stream serialisation.   Revision: 1.0      |
// +--------------------------------------------------------------------------+
module srt_result_collector #(
  parameter int OUT_WIDTH   = 16,
  parameter int SRT_LATENCY = 6,
  parameter int FIFO_DEPTH  = 8
) (
  input  wire logic                       aclk,
  input  wire logic                       areset,
  srt_result_collector_if.slave           bus,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = 3 * OUT_WIDTH;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] BEAT_B0 = 2'd0;
  localparam logic [1:0] BEAT_B1 = 2'd1;
  localparam logic [1:0] BEAT_B2 = 2'd2;

  logic                 w_issue, w_cap_en, w_hs, w_pop, w_push, w_full;
  logic [CW:0]          w_credit;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [1:0]           beat_q, beat_d;
  logic                 overflow_q;
  logic [WW-1:0]        mem_q [FIFO_DEPTH];
  logic [WW-1:0]        w_head;
  logic [OUT_WIDTH-1:0] w_word;

  // Every issued vector reserves a FIFO slot until its packet leaves.
  assign w_credit    = {1'b0, count_q} + {1'b0, inflight_q};
  assign bus.s_ready = !areset && (w_credit < DEPTH_C);
  assign w_issue     = bus.s_valid && bus.s_ready;

  // Stage 0 is the issue itself, so results are captured at the edge that
  // ends cycle issue+SRT_LATENCY-1.
  generate
    if (SRT_LATENCY == 1) begin : g_lat_one
      assign w_cap_en = w_issue;
    end else begin : g_lat_multi
      logic [SRT_LATENCY-2:0] dl_q;
      logic [SRT_LATENCY-1:0] w_shift;
      assign w_shift  = {dl_q, w_issue};
      assign w_cap_en = w_shift[SRT_LATENCY-1];
      always_ff @(posedge aclk) begin
        if (areset) dl_q <= '0;
        else        dl_q <= w_shift[SRT_LATENCY-2:0];
      end
    end
  endgenerate

  assign w_full = (count_q == CW'(FIFO_DEPTH));
  assign w_hs   = bus.m_axis_tvalid && bus.m_axis_tready;
  assign w_pop  = w_hs && (beat_q == BEAT_B2);
  assign w_push = w_cap_en && (!w_full || w_pop);

  always_comb begin
    inflight_d = inflight_q;
    if (w_issue && !w_cap_en)      inflight_d = inflight_q + CW'(1);
    else if (!w_issue && w_cap_en) inflight_d = inflight_q - CW'(1);
  end

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + CW'(1);
    else if (!w_push && w_pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    beat_d = beat_q;
    if (w_hs) beat_d = (beat_q == BEAT_B2) ? BEAT_B0 : beat_q + 2'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= BEAT_B0;
      overflow_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (w_cap_en && w_full && !w_pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset && w_push) mem_q[wr_ptr_q] <= {bus.result2, bus.result1, bus.result0};
  end

  assign w_head = mem_q[rd_ptr_q];

  always_comb begin
    w_word = w_head[OUT_WIDTH-1:0];
    case (beat_q)
      BEAT_B1: w_word = w_head[2*OUT_WIDTH-1:OUT_WIDTH];
      BEAT_B2: w_word = w_head[3*OUT_WIDTH-1:2*OUT_WIDTH];
      default: w_word = w_head[OUT_WIDTH-1:0];
    endcase
  end

  assign bus.m_axis_tvalid = (count_q != '0);
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? w_word : '0;
  assign bus.m_axis_tlast  = (beat_q == BEAT_B2) && bus.m_axis_tvalid;
  assign fifo_level        = count_q;
  assign overflow          = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_srt_result_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_srt_result_collector: table vectors, directed corner sequences and    |
// | randomized traffic against a packet-queue reference.   Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_srt_result_collector;
  localparam int W     = 16;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;

  logic aclk = 1'b0;
  logic areset;
  logic [3:0] fifo_level;
  logic overflow;

  srt_result_collector_if #(.OUT_WIDTH(W)) bus ();

  srt_result_collector #(.OUT_WIDTH(W), .SRT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic sv; logic tr; logic [W-1:0] r0; logic [W-1:0] r1; logic [W-1:0] r2;
    logic e_rdy; logic e_vld; logic [W-1:0] e_data; logic e_last; logic [3:0] e_lvl;
  } vec_t;

  typedef struct { int rdy; logic [W-1:0] data; bit last; } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 0;
  int outstanding = 0;
  int n_issued = 0;
  beat_t q[$];
  logic [3*W-1:0] res_due [int];
  logic [3*W-1:0] last_trip;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Systolic unit stand-in: results appear LAT-1 cycles after issue, garbage otherwise.
  task automatic to_sample();
    if (model_on) begin
      if (res_due.exists(cyc)) begin
        {bus.result2, bus.result1, bus.result0} = res_due[cyc];
        res_due.delete(cyc);
      end else begin
        bus.result0 = W'($urandom); bus.result1 = W'($urandom); bus.result2 = W'($urandom);
      end
    end
    @(negedge aclk);
  endtask

  task automatic finish_cycle();
    bit ev, er;
    int lvl;
    beat_t b;
    if (model_on) begin
      ev = (q.size() > 0) && (cyc >= q[0].rdy);
      er = !areset && (outstanding < DEPTH);
      chk("tvalid", bus.m_axis_tvalid, ev);
      if (ev) begin
        chk("tdata", bus.m_axis_tdata, q[0].data);
        chk("tlast", bus.m_axis_tlast, q[0].last);
      end else begin
        chk("tdata_idle", bus.m_axis_tdata, 0);
        chk("tlast_idle", bus.m_axis_tlast, 0);
      end
      chk("s_ready", bus.s_ready, er);
      lvl = 0;
      foreach (q[i]) if (q[i].last && q[i].rdy <= cyc) lvl++;
      chk("fifo_level", fifo_level, lvl);
      chk("overflow", overflow, 0);
      if (bus.s_valid && er) begin
        last_trip = {W'($urandom), W'($urandom), W'($urandom)};
        res_due[cyc + LAT - 1] = last_trip;
        for (int k = 0; k < 3; k++) begin
          b.rdy = cyc + LAT; b.data = last_trip[k*W +: W]; b.last = (k == 2);
          q.push_back(b);
        end
        outstanding++;
        n_issued++;
      end
      if (ev && bus.m_axis_tready) begin
        if (q[0].last) outstanding--;
        void'(q.pop_front());
      end
      if (areset) begin
        q.delete();
        outstanding = 0;
      end
    end
    @(posedge aclk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    areset = 1'b1; bus.s_valid = 1'b0; bus.m_axis_tready = 1'b0;
    @(negedge aclk); @(posedge aclk); #1;
    areset = 1'b0; cyc = 0; q.delete(); outstanding = 0; n_issued = 0;
    res_due.delete(); model_on = 1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tvalid"}, bus.m_axis_tvalid, 0);
    chk({tag, "_tlast"}, bus.m_axis_tlast, 0);
    chk({tag, "_tdata"}, bus.m_axis_tdata, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  vec_t tbl[10];
  logic [3*W-1:0] p0, pn;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single vector, tready high: beats at cycles 6,7,8 and tlast on the last.
    tbl[0] = '{1'b1, 1'b1, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
    tbl[1] = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
    tbl[2] = '{1'b0, 1'b1, 16'hDEAD, 16'hC0DE, 16'h0F0F, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
    tbl[3] = '{1'b0, 1'b1, 16'h7777, 16'h8888, 16'h9999, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
    tbl[4] = '{1'b0, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
    tbl[5] = '{1'b0, 1'b1, 16'h0011, 16'h0022, 16'h0033, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
    tbl[6] = '{1'b0, 1'b1, 16'hEEEE, 16'hDDDD, 16'h1111, 1'b1, 1'b1, 16'h0011, 1'b0, 4'd1};
    tbl[7] = '{1'b0, 1'b1, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b1, 16'h0022, 1'b0, 4'd1};
    tbl[8] = '{1'b0, 1'b1, 16'h5555, 16'h6666, 16'h7777, 1'b1, 1'b1, 16'h0033, 1'b1, 4'd1};
    tbl[9] = '{1'b0, 1'b1, 16'h9999, 16'h8888, 16'h7777, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};

    areset = 1'b1; bus.s_valid = 1'b0; bus.m_axis_tready = 1'b0;
    bus.result0 = '0; bus.result1 = '0; bus.result2 = '0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk_reset_values("rst");
    @(posedge aclk); #1;
    areset = 1'b0; cyc = 0;

    for (int i = 0; i < 10; i++) begin
      bus.s_valid = tbl[i].sv; bus.m_axis_tready = tbl[i].tr;
      bus.result0 = tbl[i].r0; bus.result1 = tbl[i].r1; bus.result2 = tbl[i].r2;
      @(negedge aclk);
      chk("tbl_s_ready", bus.s_ready, tbl[i].e_rdy);
      chk("tbl_tvalid", bus.m_axis_tvalid, tbl[i].e_vld);
      chk("tbl_tdata", bus.m_axis_tdata, tbl[i].e_data);
      chk("tbl_tlast", bus.m_axis_tlast, tbl[i].e_last);
      chk("tbl_level", fifo_level, tbl[i].e_lvl);
      chk("tbl_overflow", overflow, 0);
      @(posedge aclk); #1;
      cyc++;
    end

    // Fill with tready low: exactly DEPTH issues, then s_ready held low.
    do_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      to_sample();
      chk("fill_s_ready", bus.s_ready, cyc < 8);
      if (cyc == 14) chk("fill_level", fifo_level, 8);
      finish_cycle();
    end
    chk("fill_issues", n_issued, 8);

    // Credit-full cycle with a capture and a pop landing together.
    do_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.m_axis_tready = (cyc >= 10 && cyc <= 12);
      to_sample();
      if (cyc == 12) begin
        chk("full_s_ready_low", bus.s_ready, 0);
        chk("full_tlast", bus.m_axis_tlast, 1);
        chk("full_level_before", fifo_level, 7);
      end
      if (cyc == 13) begin
        chk("full_level_after", fifo_level, 7);
        chk("full_credit_release", bus.s_ready, 1);
      end
      finish_cycle();
    end
    bus.s_valid = 1'b0; bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin to_sample(); finish_cycle(); end
    chk("full_drained", q.size(), 0);

    // Backpressure held for three cycles while beat 1 is presented.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.s_valid = (cyc < 2);
      bus.m_axis_tready = !(cyc >= 7 && cyc <= 9);
      to_sample();
      if (cyc >= 7 && cyc <= 9) begin
        chk("bp_tvalid", bus.m_axis_tvalid, 1);
        chk("bp_tdata", bus.m_axis_tdata, p0[2*W-1:W]);
      end
      finish_cycle();
      if (cyc == 1) p0 = last_trip;
    end
    chk("bp_drained", q.size(), 0);

    // One-cycle reset with 2 packets buffered and 3 vectors in flight.
    do_reset();
    pn = '0;
    for (int i = 0; i < 22; i++) begin
      bus.s_valid = (cyc < 2) || (cyc >= 6 && cyc <= 8) || (cyc == 12);
      areset = (cyc == 9);
      to_sample();
      if (cyc == 9) chk("rst_pre_level", fifo_level, 2);
      if (cyc == 10) begin
        chk_reset_values("rst_mid");
        chk("rst_mid_s_ready", bus.s_ready, 1);
      end
      if (cyc == 17) chk("rst_new_not_yet", bus.m_axis_tvalid, 0);
      if (cyc == 18) begin
        chk("rst_new_tvalid", bus.m_axis_tvalid, 1);
        chk("rst_new_tdata", bus.m_axis_tdata, pn[W-1:0]);
      end
      finish_cycle();
      if (cyc == 13) pn = last_trip;
    end
    bus.s_valid = 1'b0; bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin to_sample(); finish_cycle(); end
    chk("rst_drained", q.size(), 0);

    // Randomized traffic: 20 packets, 50% tready, random issue requests.
    do_reset();
    for (int k = 0; k < 3000 && n_issued < 20; k++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      to_sample();
      finish_cycle();
    end
    bus.s_valid = 1'b0;
    for (int k = 0; k < 600 && q.size() > 0; k++) begin
      bus.m_axis_tready = 1'($urandom_range(0, 1));
      to_sample();
      finish_cycle();
    end
    chk("rand_issued", n_issued, 20);
    chk("rand_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
